// File: rtl/debounce_pkg.sv
// ---------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the debounce / edge-detect block:
//   state_t - 2-bit stability FSM encoding. Bit 0 set means a level change
//             is being qualified, and bit 1 holds the currently accepted level.
//   clog2   - ceiling log2 helper. Sizes the qualification counter at
//             elaboration time.
// ---------------------------------------------------------------------------
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    CHECK_HI  = 2'b01,
    STABLE_HI = 2'b10,
    CHECK_LO  = 2'b11
  } state_t;

  // Number of bits needed to hold values 0 .. value-1 (minimum 0).
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/debounce_edge_detect_sync_chain.sv
// ---------------------------------------------------------------------------
// sync_chain
// A generic multi-flop synchronizer for a single asynchronous bit. It is
// reusable by any block that must bring an external signal into the clk
// domain.
//
// Parameters:
//   SYNC_STAGES - number of flops in the chain (>= 2)
//   RESET_LEVEL - value every flop takes while reset is high
//
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous, active-high reset
//   async_bit - raw input, not yet synchronized
//   synced   - output of the last flop in the chain
// ---------------------------------------------------------------------------
module sync_chain #(
  parameter int SYNC_STAGES = 2,
  parameter bit RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_bit,
  output logic synced
);

  // A single flop gives no metastability protection, so refuse to build one.
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("sync_chain: SYNC_STAGES must be >= 2");
  end

  logic [SYNC_STAGES-1:0] stages;

  // Shift chain. Index 0 captures the raw input, and the top index is the
  // settled output. Reset preloads the idle level, so that releasing reset
  // does not look like an input edge to whatever follows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stages <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], async_bit};
    end
  end

  assign synced = stages[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_edge_detect.sv
// ---------------------------------------------------------------------------
// debounce_edge_detect
// Turns a noisy asynchronous 1-bit input (button, external strobe) into a
// clean registered level. It also produces one-cycle rise/fall pulses. The
// input is synchronized first. A four-state FSM then requires the synced
// level to stay at a new value for STABLE_CYCLES tick-qualified cycles before
// q follows it. Any return to the old level during qualification rejects the
// change and restarts the count from zero next time.
//
// Parameters:
//   SYNC_STAGES   - synchronizer depth (>= 2)
//   STABLE_CYCLES - tick-qualified cycles a new level must hold (>= 1)
//   RESET_LEVEL   - idle level of q and the synchronizer during reset
//
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high reset
//   data  - raw asynchronous input
//   tick  - counter sample enable (tie high to count every clock)
//   q     - debounced level (registered)
//   rise  - one-cycle pulse, same cycle q goes 0->1 (registered)
//   fall  - one-cycle pulse, same cycle q goes 1->0 (registered)
//   busy  - high while a level change is being qualified
// ---------------------------------------------------------------------------
module debounce_edge_detect
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter bit RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic data,
  input  logic tick,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  // Zero qualification cycles would make the counter compare meaningless.
  if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
    $error("debounce_edge_detect: STABLE_CYCLES must be >= 1");
  end

  localparam int               CNT_W       = clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(STABLE_CYCLES - 1);
  localparam state_t           RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

  logic             s;
  logic             qualified;
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             q_next;
  logic             rise_next;
  logic             fall_next;

  sync_chain #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_LEVEL (RESET_LEVEL)
  ) u_sync (
    .clk       (clk),
    .reset     (reset),
    .async_bit (data),
    .synced    (s)
  );

  // The last qualifying tick. It is only meaningful in a CHECK state while the
  // synced input still holds the candidate level.
  always_comb begin
    qualified = tick && (cnt == CNT_LAST);
  end

  // State register, qualification counter and registered outputs. Reset
  // lands directly in the idle state that matches RESET_LEVEL, so that
  // releasing reset never fires a pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RESET_STATE;
      cnt   <= '0;
      q     <= RESET_LEVEL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      q     <= q_next;
      rise  <= rise_next;
      fall  <= fall_next;
    end
  end

  // Next-state and counter logic. Entering a CHECK state always starts from
  // zero and ignores tick on that edge. Leaving a CHECK state also clears
  // the counter, so cnt is zero whenever the FSM is stable. The counter
  // stops at CNT_LAST because that is where the CHECK state completes, so it
  // cannot wrap.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      STABLE_LO: begin
        if (s) begin
          state_next = CHECK_HI;
          cnt_next   = '0;
        end
      end
      CHECK_HI: begin
        if (!s) begin
          state_next = STABLE_LO;
          cnt_next   = '0;
        end else if (qualified) begin
          state_next = STABLE_HI;
          cnt_next   = '0;
        end else if (tick) begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_next = CHECK_LO;
          cnt_next   = '0;
        end
      end
      CHECK_LO: begin
        if (s) begin
          state_next = STABLE_HI;
          cnt_next   = '0;
        end else if (qualified) begin
          state_next = STABLE_LO;
          cnt_next   = '0;
        end else if (tick) begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = RESET_STATE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output logic. q only moves on a completed qualification, and the
  // matching pulse is registered alongside it, so the pulse appears in the
  // same cycle as the level change. The pulses default low, so each lasts
  // exactly one cycle. Because only one CHECK state can complete at a time,
  // rise and fall are exclusive.
  always_comb begin
    q_next    = q;
    rise_next = 1'b0;
    fall_next = 1'b0;
    if (state == CHECK_HI && s && qualified) begin
      q_next    = 1'b1;
      rise_next = 1'b1;
    end else if (state == CHECK_LO && !s && qualified) begin
      q_next    = 1'b0;
      fall_next = 1'b1;
    end
  end

  // busy comes straight from the state register, so it is high in both
  // CHECK states.
  always_comb begin
    busy = (state == CHECK_HI) || (state == CHECK_LO);
  end

endmodule

// File: tb/tb_debounce_edge_detect.sv
// ---------------------------------------------------------------------------
// tb_debounce_edge_detect
// Drives two instances side by side, one with RESET_LEVEL=0 and one with
// RESET_LEVEL=1, from shared data/tick/reset. Both use SYNC_STAGES=2 and
// STABLE_CYCLES=4.
//
// For each instance, a reference model describes the behaviour in terms of
// rules. The new level is seen SYNC_STAGES edges after it is sampled. A
// differing level must survive STABLE_CYCLES ticks after the edge that
// first sees it before q follows. Any return to q's level cancels the
// attempt.
//
// The driver pushes the expected outputs for every cycle into a scoreboard
// queue. A monitor on the falling edge pops each entry and compares it.
// ---------------------------------------------------------------------------
module tb_debounce_edge_detect;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;

  logic clk;
  logic reset;
  logic data;
  logic tick;
  logic q0, rise0, fall0, busy0;
  logic q1, rise1, fall1, busy1;

  debounce_edge_detect #(
    .SYNC_STAGES   (SYNC),
    .STABLE_CYCLES (STABLE),
    .RESET_LEVEL   (1'b0)
  ) dut0 (
    .clk   (clk),
    .reset (reset),
    .data  (data),
    .tick  (tick),
    .q     (q0),
    .rise  (rise0),
    .fall  (fall0),
    .busy  (busy0)
  );

  debounce_edge_detect #(
    .SYNC_STAGES   (SYNC),
    .STABLE_CYCLES (STABLE),
    .RESET_LEVEL   (1'b1)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .data  (data),
    .tick  (tick),
    .q     (q1),
    .rise  (rise1),
    .fall  (fall1),
    .busy  (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {q, rise, fall, busy} for each instance after a given edge
  typedef struct {
    int         cycle;
    logic [3:0] v0;
    logic [3:0] v1;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;
  int   cycle;

  // Reference model state, one slot per instance
  bit lvl   [2];
  bit hist  [2][SYNC];
  bit m_q   [2];
  bit m_rise[2];
  bit m_fall[2];
  bit m_busy[2];
  int m_run [2];

  function automatic void modelReset(input int i);
    for (int j = 0; j < SYNC; j++) hist[i][j] = lvl[i];
    m_q[i]    = lvl[i];
    m_rise[i] = 1'b0;
    m_fall[i] = 1'b0;
    m_busy[i] = 1'b0;
    m_run[i]  = 0;
  endfunction

  // One clock edge. seen is the level sampled SYNC edges ago. A differing
  // level starts an attempt on the edge that first sees it. The attempt
  // completes after STABLE further tick-high edges, provided the level
  // never returned to q in between.
  function automatic void modelEdge(input int i, input bit d, input bit t, input bit r);
    bit seen;
    if (r) begin
      modelReset(i);
      return;
    end
    seen = hist[i][SYNC-1];
    for (int j = SYNC - 1; j > 0; j--) hist[i][j] = hist[i][j-1];
    hist[i][0] = d;
    m_rise[i] = 1'b0;
    m_fall[i] = 1'b0;
    if (seen == m_q[i]) begin
      m_busy[i] = 1'b0;
      m_run[i]  = 0;
    end else if (!m_busy[i]) begin
      m_busy[i] = 1'b1;
      m_run[i]  = 0;
    end else if (t) begin
      m_run[i]++;
      if (m_run[i] == STABLE) begin
        m_q[i]    = seen;
        m_rise[i] = seen;
        m_fall[i] = !seen;
        m_busy[i] = 1'b0;
        m_run[i]  = 0;
      end
    end
  endfunction

  // Waits for a clock edge and advances the model with the inputs that edge
  // saw. It then changes the inputs between edges; asserting reset here
  // clears the model at once. Finally it queues what the monitor must see
  // before the next edge.
  task automatic applyStimulus(input bit d, input bit t, input bit r);
    exp_t e;
    @(posedge clk);
    for (int i = 0; i < 2; i++) modelEdge(i, data, tick, reset);
    #1;
    data  = d;
    tick  = t;
    reset = r;
    if (r) begin
      modelReset(0);
      modelReset(1);
    end
    cycle++;
    e.cycle = cycle;
    e.v0    = {m_q[0], m_rise[0], m_fall[0], m_busy[0]};
    e.v1    = {m_q[1], m_rise[1], m_fall[1], m_busy[1]};
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic got, input logic expv, input int cyc);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %b expected %b", name, cyc, got, expv);
    end
  endtask

  // The monitor pops one scoreboard entry per cycle, half a period after the
  // driver updated the inputs.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("dut0.q",    q0,    e.v0[3], e.cycle);
      checkOutput("dut0.rise", rise0, e.v0[2], e.cycle);
      checkOutput("dut0.fall", fall0, e.v0[1], e.cycle);
      checkOutput("dut0.busy", busy0, e.v0[0], e.cycle);
      checkOutput("dut1.q",    q1,    e.v1[3], e.cycle);
      checkOutput("dut1.rise", rise1, e.v1[2], e.cycle);
      checkOutput("dut1.fall", fall1, e.v1[1], e.cycle);
      checkOutput("dut1.busy", busy1, e.v1[0], e.cycle);
    end
  end

  initial begin
    bit d;
    bit t;
    bit r;
    bit gate;
    int len;

    checks = 0;
    errors = 0;
    cycle  = 0;
    lvl[0] = 1'b0;
    lvl[1] = 1'b1;
    modelReset(0);
    modelReset(1);
    reset = 1'b1;
    data  = 1'b1;
    tick  = 1'b1;

    // Reset held with data high, then release and let q rise
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b1);
    repeat (12) applyStimulus(1'b1, 1'b1, 1'b0);

    // Fall, then a 3-cycle high glitch that must be rejected
    repeat (12) applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (12) applyStimulus(1'b0, 1'b1, 1'b0);

    // Clean rise and fall with per-clock ticks
    repeat (12) applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (12) applyStimulus(1'b0, 1'b1, 1'b0);

    // Tick on every third cycle: step high and hold, then step low and hold
    for (int c = 0; c < 30; c++) applyStimulus(1'b1, (c % 3) == 0, 1'b0);
    for (int c = 0; c < 30; c++) applyStimulus(1'b0, (c % 3) == 0, 1'b0);
    // Step high again, with a 1-cycle low glitch on a tick-low cycle
    for (int c = 0; c < 7; c++) applyStimulus(1'b1, (c % 3) == 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, (c % 3) == 0, 1'b0);
    repeat (10) applyStimulus(1'b0, 1'b1, 1'b0);

    // Async reset mid-qualification (cnt=2), then the full latency again
    repeat (5) applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    repeat (12) applyStimulus(1'b1, 1'b1, 1'b0);

    // Reset with data low: the RESET_LEVEL=1 instance must fall afterwards
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b1);
    repeat (12) applyStimulus(1'b0, 1'b1, 1'b0);

    // Reset right after a rise pulse, so that the pulse drops immediately
    repeat (6) applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0);

    // Randomized runs of random length, with free-running or sparse ticks
    // and occasional resets
    for (int n = 0; n < 150; n++) begin
      d    = 1'($urandom_range(0, 1));
      len  = $urandom_range(1, 12);
      gate = 1'($urandom_range(0, 1));
      for (int j = 0; j < len; j++) begin
        t = gate ? ($urandom_range(0, 2) == 0) : 1'b1;
        r = ($urandom_range(0, 199) == 0);
        applyStimulus(d, t, r);
      end
    end

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
